// File: rtl/risc_mgmt_pkg.sv
// Shared types for the risc_mgmt extension memory channel: responder FSM
// states, the latched request record and the byte-enable alignment rule.
package risc_mgmt_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BEN_W  = MEM_DATA_W / 8;

    // Responder states: waiting, bus transfer issued, completion pulse, error pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mem_resp_state_t;

    // Copy of the initiator request taken when the bus is granted, so the
    // initiator may change its inputs while the transfer is in flight.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BEN_W-1:0]  ben;
        logic                  is_store;
    } mem_req_t;

    // Address must be aligned to the span covered by the byte enables:
    // full word needs addr[1:0]==0, either halfword needs addr[0]==0.
    // Single-byte and other patterns carry no alignment constraint.
    function automatic logic ben_aligned(input logic [1:0]           addr_lo,
                                         input logic [MEM_BEN_W-1:0] ben);
        logic ok;
        ok = 1'b1;
        if (ben == 4'b1111) begin
            ok = (addr_lo == 2'b00);
        end else if ((ben == 4'b0011) || (ben == 4'b1100)) begin
            ok = (addr_lo[0] == 1'b0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/risc_mgmt_mem_responder_if.sv
// Extension memory channel between an extension memory stage (master,
// raises requests) and the responder (slave, returns busy/load/err).
interface risc_mgmt_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ren;
    logic                  wen;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     store;
    logic [DATA_W/8-1:0]   ben;
    logic                  busy;
    logic [DATA_W-1:0]     load;
    logic                  err;

    // Initiator side: holds ren/wen until busy drops
    modport master (
        output ren, wen, addr, store, ben,
        input  busy, load, err
    );

    // Responder side
    modport slave (
        input  ren, wen, addr, store, ben,
        output busy, load, err
    );
endinterface

// File: rtl/risc_mgmt_mem_responder.sv
// Responder end of the risc_mgmt extension memory channel. Takes a load or
// store from an extension memory stage, waits until the core pipeline is not
// using the data bus, issues the transfer from a latched copy, holds the
// initiator busy until the bus completes, then returns load data (DONE) or
// a one-cycle error (ERR) for bad requests and bus timeouts.
module risc_mgmt_mem_responder
    import risc_mgmt_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    risc_mgmt_mem_responder_if.slave ext_mem,
    input  logic                    core_mem_req,
    output logic [ADDR_W-1:0]       dbus_addr,
    output logic [DATA_W-1:0]       dbus_wdata,
    output logic                    dbus_ren,
    output logic                    dbus_wen,
    output logic [DATA_W/8-1:0]     dbus_ben,
    input  logic                    dbus_busy,
    input  logic [DATA_W-1:0]       dbus_rdata
);

    // Counter is at least 8 bits and wide enough to reach TIMEOUT_CYC
    localparam int CNT_NEED = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W    = (CNT_NEED > 8) ? CNT_NEED : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

    mem_resp_state_t    state_reg, state_next;
    mem_req_t           req_reg, req_next;
    logic [DATA_W-1:0]  load_reg, load_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic               req_present;
    logic               req_bad;
    logic [CNT_W-1:0]   req_cycles;
    logic               busy_c;
    logic               err_c;
    logic [DATA_W-1:0]  load_c;

    assign req_present = ext_mem.ren | ext_mem.wen;
    // Both strobes at once or a misaligned access never reaches the bus
    assign req_bad     = (ext_mem.ren & ext_mem.wen) |
                         ~ben_aligned(ext_mem.addr[1:0], ext_mem.ben);
    // REQ cycles including the current one; saturates instead of wrapping
    assign req_cycles  = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

    // State, request latch, load data and timeout counter; reset abandons any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            req_reg   <= '0;
            load_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            load_reg  <= load_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and output decode; bus strobes only ever come from REQ
    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        load_next  = load_reg;
        cnt_next   = cnt_reg;
        busy_c     = 1'b0;
        err_c      = 1'b0;
        load_c     = '0;
        dbus_addr  = '0;
        dbus_wdata = '0;
        dbus_ben   = '0;
        dbus_ren   = 1'b0;
        dbus_wen   = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_c = req_present;
                if (req_present) begin
                    if (req_bad) begin
                        state_next = ERR;
                    end else if (!core_mem_req) begin
                        // Core does not want the bus: take the request
                        req_next.addr     = ext_mem.addr;
                        req_next.wdata    = ext_mem.store;
                        req_next.ben      = ext_mem.ben;
                        req_next.is_store = ext_mem.wen;
                        load_next         = '0;
                        cnt_next          = '0;
                        state_next        = REQ;
                    end
                end
            end

            REQ: begin
                // Issued transfer runs to completion; core_mem_req ignored here
                busy_c     = 1'b1;
                dbus_addr  = req_reg.addr;
                dbus_wdata = req_reg.wdata;
                dbus_ben   = req_reg.ben;
                dbus_ren   = ~req_reg.is_store;
                dbus_wen   = req_reg.is_store;
                cnt_next   = req_cycles;
                if (!dbus_busy) begin
                    load_next  = req_reg.is_store ? '0 : dbus_rdata;
                    state_next = DONE;
                end else if (TIMEOUT_EN && (req_cycles == TIMEOUT_VAL)) begin
                    state_next = ERR;
                end
            end

            DONE: begin
                // Initiator sees busy low and treats its held request as consumed
                load_c     = load_reg;
                state_next = IDLE;
            end

            ERR: begin
                err_c      = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Busy is combinational from the request in IDLE, so force it low during reset
    assign ext_mem.busy = busy_c & ~rst;
    assign ext_mem.err  = err_c;
    assign ext_mem.load = load_c;

endmodule

// File: tb/tb_risc_mgmt_mem_responder.sv
// Directed bench for the extension memory responder: load with bus wait
// states, store held off by the core, bad requests, timeout, reset
// mid-transfer and back-to-back loads.
module tb_risc_mgmt_mem_responder;

    logic        clk;
    logic        rst;
    logic        core_mem_req;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ren;
    logic        dbus_wen;
    logic [3:0]  dbus_ben;
    logic        dbus_busy;
    logic [31:0] dbus_rdata;

    int checks;
    int errors;

    risc_mgmt_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    risc_mgmt_mem_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_mem      (mif),
        .core_mem_req (core_mem_req),
        .dbus_addr    (dbus_addr),
        .dbus_wdata   (dbus_wdata),
        .dbus_ren     (dbus_ren),
        .dbus_wen     (dbus_wen),
        .dbus_ben     (dbus_ben),
        .dbus_busy    (dbus_busy),
        .dbus_rdata   (dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drop_req();
        mif.ren   = 1'b0;
        mif.wen   = 1'b0;
        mif.addr  = '0;
        mif.store = '0;
        mif.ben   = '0;
    endtask

    // Watchdog: directed sequence is short, so anything this long is a hang
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        core_mem_req = 1'b0;
        dbus_busy    = 1'b1;
        dbus_rdata   = '0;
        drop_req();

        // ---- reset state
        #2;
        chk_bit ("rst_busy", mif.busy, 1'b0);
        chk_bit ("rst_err",  mif.err,  1'b0);
        chk_word("rst_load", mif.load, 32'h0);
        chk_bit ("rst_dren", dbus_ren, 1'b0);
        chk_bit ("rst_dwen", dbus_wen, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("reset released at %0t", $time);

        // ---- 1: load 0x100, bus ready on third REQ cycle
        mif.ren = 1'b1; mif.addr = 32'h100; mif.ben = 4'hF; dbus_busy = 1'b1;
        #1;
        chk_bit("t1_c0_busy", mif.busy, 1'b1);
        chk_bit("t1_c0_dren", dbus_ren, 1'b0);
        tick();
        chk_bit ("t1_c1_dren", dbus_ren, 1'b1);
        chk_word("t1_c1_addr", dbus_addr, 32'h100);
        chk_bit ("t1_c1_busy", mif.busy, 1'b1);
        tick();
        chk_bit("t1_c2_dren", dbus_ren, 1'b1);
        chk_bit("t1_c2_busy", mif.busy, 1'b1);
        tick();
        dbus_busy = 1'b0; dbus_rdata = 32'hDEADBEEF;
        #1;
        chk_bit("t1_c3_dren", dbus_ren, 1'b1);
        chk_bit("t1_c3_busy", mif.busy, 1'b1);
        tick();
        dbus_busy = 1'b1; dbus_rdata = '0;
        #1;
        chk_bit ("t1_c4_busy", mif.busy, 1'b0);
        chk_word("t1_c4_load", mif.load, 32'hDEADBEEF);
        chk_bit ("t1_c4_err",  mif.err,  1'b0);
        chk_bit ("t1_c4_dren", dbus_ren, 1'b0);
        tick();
        drop_req();
        #1;
        chk_bit ("t1_c5_busy", mif.busy, 1'b0);
        chk_word("t1_c5_load", mif.load, 32'h0);
        $display("t1 load 0x100 done checks=%0d errors=%0d", checks, errors);
        tick();

        // ---- 2: store 0x204 held off by core for 3 cycles
        mif.wen = 1'b1; mif.addr = 32'h204; mif.store = 32'h12345678; mif.ben = 4'hF;
        core_mem_req = 1'b1;
        #1;
        chk_bit("t2_c0_busy", mif.busy, 1'b1);
        chk_bit("t2_c0_dwen", dbus_wen, 1'b0);
        tick();
        chk_bit("t2_c1_dwen", dbus_wen, 1'b0);
        tick();
        chk_bit("t2_c2_dwen", dbus_wen, 1'b0);
        chk_bit("t2_c2_busy", mif.busy, 1'b1);
        tick();
        core_mem_req = 1'b0;
        #1;
        chk_bit("t2_c3_dwen", dbus_wen, 1'b0);
        chk_bit("t2_c3_busy", mif.busy, 1'b1);
        tick();
        core_mem_req = 1'b1; dbus_busy = 1'b0;
        #1;
        chk_bit ("t2_c4_dwen",  dbus_wen,   1'b1);
        chk_bit ("t2_c4_dren",  dbus_ren,   1'b0);
        chk_word("t2_c4_wdata", dbus_wdata, 32'h12345678);
        chk_word("t2_c4_ben",   {28'h0, dbus_ben}, 32'hF);
        chk_word("t2_c4_addr",  dbus_addr,  32'h204);
        chk_bit ("t2_c4_busy",  mif.busy,   1'b1);
        tick();
        dbus_busy = 1'b1;
        #1;
        chk_bit ("t2_c5_busy", mif.busy, 1'b0);
        chk_word("t2_c5_load", mif.load, 32'h0);
        chk_bit ("t2_c5_dwen", dbus_wen, 1'b0);
        tick();
        drop_req();
        core_mem_req = 1'b0;
        $display("t2 store 0x204 done checks=%0d errors=%0d", checks, errors);
        tick();

        // ---- 3a: misaligned word load
        mif.ren = 1'b1; mif.addr = 32'h102; mif.ben = 4'hF;
        #1;
        chk_bit("t3a_c0_busy", mif.busy, 1'b1);
        tick();
        chk_bit ("t3a_c1_err",  mif.err,  1'b1);
        chk_bit ("t3a_c1_busy", mif.busy, 1'b0);
        chk_bit ("t3a_c1_dren", dbus_ren, 1'b0);
        chk_word("t3a_c1_load", mif.load, 32'h0);
        tick();
        drop_req();
        #1;
        chk_bit("t3a_c2_err", mif.err, 1'b0);
        $display("t3a misaligned word done checks=%0d errors=%0d", checks, errors);
        tick();

        // ---- 3b: ren and wen together
        mif.ren = 1'b1; mif.wen = 1'b1; mif.addr = 32'h100; mif.ben = 4'hF;
        #1;
        chk_bit("t3b_c0_dren", dbus_ren, 1'b0);
        chk_bit("t3b_c0_dwen", dbus_wen, 1'b0);
        tick();
        chk_bit("t3b_c1_err",  mif.err,  1'b1);
        chk_bit("t3b_c1_dren", dbus_ren, 1'b0);
        chk_bit("t3b_c1_dwen", dbus_wen, 1'b0);
        tick();
        drop_req();
        #1;
        chk_bit("t3b_c2_err", mif.err, 1'b0);
        $display("t3b ren+wen done checks=%0d errors=%0d", checks, errors);
        tick();

        // ---- 3c: misaligned halfword
        mif.ren = 1'b1; mif.addr = 32'h103; mif.ben = 4'b0011;
        tick();
        chk_bit("t3c_c1_err",  mif.err,  1'b1);
        chk_bit("t3c_c1_dren", dbus_ren, 1'b0);
        tick();
        drop_req();
        $display("t3c misaligned halfword done checks=%0d errors=%0d", checks, errors);
        tick();

        // ---- 4: bus stuck busy, timeout after 4 REQ cycles
        mif.ren = 1'b1; mif.addr = 32'h10; mif.ben = 4'hF; dbus_busy = 1'b1;
        tick();
        chk_bit("t4_r1_dren", dbus_ren, 1'b1);
        tick();
        chk_bit("t4_r2_dren", dbus_ren, 1'b1);
        tick();
        chk_bit("t4_r3_dren", dbus_ren, 1'b1);
        tick();
        chk_bit("t4_r4_dren", dbus_ren, 1'b1);
        chk_bit("t4_r4_err",  mif.err,  1'b0);
        tick();
        chk_bit("t4_err",      mif.err,  1'b1);
        chk_bit("t4_err_busy", mif.busy, 1'b0);
        chk_bit("t4_err_dren", dbus_ren, 1'b0);
        tick();
        drop_req();
        #1;
        chk_bit("t4_after_err", mif.err, 1'b0);
        $display("t4 timeout done checks=%0d errors=%0d", checks, errors);
        tick();

        // ---- 5: reset mid-REQ, then load 0x300 completes normally
        mif.ren = 1'b1; mif.addr = 32'h300; mif.ben = 4'hF; dbus_busy = 1'b1;
        tick();
        chk_bit("t5_req_dren", dbus_ren, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk_bit("t5_rst_dren", dbus_ren, 1'b0);
        chk_bit("t5_rst_dwen", dbus_wen, 1'b0);
        chk_bit("t5_rst_busy", mif.busy, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk_bit("t5_idle_busy", mif.busy, 1'b1);
        chk_bit("t5_idle_dren", dbus_ren, 1'b0);
        tick();
        dbus_busy = 1'b0; dbus_rdata = 32'hCAFEF00D;
        #1;
        chk_bit ("t5_req2_dren", dbus_ren,  1'b1);
        chk_word("t5_req2_addr", dbus_addr, 32'h300);
        tick();
        dbus_busy = 1'b1; dbus_rdata = '0;
        #1;
        chk_word("t5_done_load", mif.load, 32'hCAFEF00D);
        chk_bit ("t5_done_busy", mif.busy, 1'b0);
        tick();
        drop_req();
        $display("t5 reset mid-transfer done checks=%0d errors=%0d", checks, errors);
        tick();

        // ---- 6: back-to-back loads 0x0 then 0x4
        mif.ren = 1'b1; mif.addr = 32'h0; mif.ben = 4'hF;
        dbus_busy = 1'b0; dbus_rdata = 32'h11111111;
        #1;
        chk_bit("t6_a_c0_busy", mif.busy, 1'b1);
        tick();
        chk_bit ("t6_a_dren", dbus_ren,  1'b1);
        chk_word("t6_a_addr", dbus_addr, 32'h0);
        tick();
        dbus_rdata = 32'h0;
        #1;
        chk_word("t6_a_load", mif.load, 32'h11111111);
        chk_bit ("t6_a_busy", mif.busy, 1'b0);
        tick();
        mif.addr = 32'h4; dbus_rdata = 32'h22222222;
        #1;
        chk_bit("t6_b_c0_busy", mif.busy, 1'b1);
        chk_bit("t6_b_c0_dren", dbus_ren, 1'b0);
        tick();
        chk_bit ("t6_b_dren", dbus_ren,  1'b1);
        chk_word("t6_b_addr", dbus_addr, 32'h4);
        tick();
        dbus_rdata = 32'h0;
        #1;
        chk_word("t6_b_load", mif.load, 32'h22222222);
        chk_bit ("t6_b_busy", mif.busy, 1'b0);
        tick();
        drop_req();
        dbus_busy = 1'b1;
        #1;
        chk_bit("t6_end_busy", mif.busy, 1'b0);
        chk_bit("t6_end_dren", dbus_ren, 1'b0);
        $display("t6 back-to-back loads done checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
